// File: rtl/coin_latch_counter_if.sv
// Bus between the CPU output-decode logic and coin_latch_counter.
// The master drives the latch write strobe, address and data. The slave returns
// the latch contents and the coin/store outputs.
// Optional feature macro: COIN_LATCH_OVF_EN adds the per-channel coin_ovf flags.
interface coin_latch_counter_if #(
    parameter int ADDR_W   = 3,
    parameter int NUM_COIN = 2
);
    logic                     OUTn;
    logic [ADDR_W-1:0]        BA;
    logic                     BD;
    logic [(2**ADDR_W)-1:0]   q;
    logic [NUM_COIN-1:0]      coin_out;
    logic [NUM_COIN-1:0]      coin_busy;
    logic                     store_pulse;
`ifdef COIN_LATCH_OVF_EN
    logic [NUM_COIN-1:0]      coin_ovf;

    modport master (output OUTn, BA, BD,
                    input  q, coin_out, coin_busy, store_pulse, coin_ovf);
    modport slave  (input  OUTn, BA, BD,
                    output q, coin_out, coin_busy, store_pulse, coin_ovf);
`else
    modport master (output OUTn, BA, BD,
                    input  q, coin_out, coin_busy, store_pulse);
    modport slave  (input  OUTn, BA, BD,
                    output q, coin_out, coin_busy, store_pulse);
`endif
endinterface

// File: rtl/coin_latch_counter.sv
// coin_latch_counter: addressable output latch (259-style) with per-channel
// coin-counter pulse shaping and an NVRAM store strobe.
// Each 0->1 edge on a coin bit queues one count. Each count is played out as a
// PULSE_CYC-cycle high pulse followed by at least GAP_CYC low cycles.
// Optional feature macro: COIN_LATCH_OVF_EN adds sticky per-channel overflow
// flags (coin_ovf) for increments dropped at pending-count saturation.
module coin_latch_counter #(
    parameter int                    ADDR_W    = 3,
    parameter logic [(2**ADDR_W)-1:0] RESET_VAL = {(2**ADDR_W){1'b0}},
    parameter int                    NUM_COIN  = 2,
    parameter int                    COIN_BASE = 5,
    parameter int                    PULSE_CYC = 16,
    parameter int                    GAP_CYC   = 16,
    parameter int                    CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    coin_latch_counter_if.slave  bus
);
    localparam int NBITS   = 2**ADDR_W;
    localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [NBITS-1:0]    q_r;
    logic [NBITS-1:0]    q_nxt_s;
    logic [NBITS-1:0]    hist_r;
    logic [NBITS-1:0]    rise_s;
    logic                store_r;
    logic                store_nxt_s;
    logic [NUM_COIN-1:0] inc_s;
    logic [NUM_COIN-1:0] start_s;
    logic [NUM_COIN-1:0] drop_s;
    logic [NUM_COIN-1:0] coin_out_r;
    logic [NUM_COIN-1:0] busy_r;
    logic [NUM_COIN-1:0] busy_nxt_s;

    logic [1:0]          state_r     [NUM_COIN];
    logic [1:0]          state_nxt_s [NUM_COIN];
    logic [TMR_W-1:0]    timer_r     [NUM_COIN];
    logic [TMR_W-1:0]    timer_nxt_s [NUM_COIN];
    logic [CNT_W-1:0]    pend_r      [NUM_COIN];
    logic [CNT_W-1:0]    pend_nxt_s  [NUM_COIN];

    // Latch write: only the addressed bit changes, and only while OUTn is low
    always_comb begin
        q_nxt_s = q_r;
        if (!bus.OUTn) begin
            q_nxt_s[bus.BA] = bus.BD;
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Rising edges of the latch bits and the store condition edge
    always_comb begin
        rise_s      = q_r & ~hist_r;
        store_nxt_s = (q_nxt_s[3] & ~q_nxt_s[2]) & ~(q_r[3] & ~q_r[2]);
        for (int i = 0; i < NUM_COIN; i++) begin
            inc_s[i] = rise_s[COIN_BASE + i];
        end
    end

    // Per-channel sequencing: pulse/gap timing and pending-count bookkeeping
    always_comb begin
        start_s    = {NUM_COIN{1'b0}};
        drop_s     = {NUM_COIN{1'b0}};
        busy_nxt_s = {NUM_COIN{1'b0}};
        for (int i = 0; i < NUM_COIN; i++) begin
            state_nxt_s[i] = state_r[i];
            timer_nxt_s[i] = timer_r[i];
            pend_nxt_s[i]  = pend_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (pend_r[i] != CNT_ZERO) begin
                        state_nxt_s[i] = ST_PULSE;
                        timer_nxt_s[i] = PULSE_LOAD;
                        start_s[i]     = 1'b1;
                    end else begin
                        timer_nxt_s[i] = TMR_ZERO;
                    end
                end
                ST_PULSE: begin
                    if (timer_r[i] == TMR_ZERO) begin
                        state_nxt_s[i] = ST_GAP;
                        timer_nxt_s[i] = GAP_LOAD;
                    end else begin
                        timer_nxt_s[i] = timer_r[i] - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (timer_r[i] != TMR_ZERO) begin
                        timer_nxt_s[i] = timer_r[i] - TMR_ONE;
                    end else if (pend_r[i] != CNT_ZERO) begin
                        state_nxt_s[i] = ST_PULSE;
                        timer_nxt_s[i] = PULSE_LOAD;
                        start_s[i]     = 1'b1;
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                        timer_nxt_s[i] = TMR_ZERO;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                    timer_nxt_s[i] = TMR_ZERO;
                end
            endcase

            // A count arriving while one is consumed leaves the total unchanged
            if (inc_s[i] && start_s[i]) begin
                pend_nxt_s[i] = pend_r[i];
            end else if (inc_s[i]) begin
                if (pend_r[i] != CNT_MAX) begin
                    pend_nxt_s[i] = pend_r[i] + CNT_ONE;
                end else begin
                    pend_nxt_s[i] = pend_r[i];
                    drop_s[i]     = 1'b1;
                end
            end else if (start_s[i]) begin
                pend_nxt_s[i] = pend_r[i] - CNT_ONE;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end

            busy_nxt_s[i] = (state_nxt_s[i] != ST_IDLE) || (pend_nxt_s[i] != CNT_ZERO);
        end
    end

    // State registers; outputs are registered from next-state values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r        <= RESET_VAL;
            hist_r     <= RESET_VAL;
            store_r    <= 1'b0;
            coin_out_r <= {NUM_COIN{1'b0}};
            busy_r     <= {NUM_COIN{1'b0}};
            for (int i = 0; i < NUM_COIN; i++) begin
                state_r[i] <= ST_IDLE;
                timer_r[i] <= TMR_ZERO;
                pend_r[i]  <= CNT_ZERO;
            end
        end else begin
            q_r     <= q_nxt_s;
            hist_r  <= q_r;
            store_r <= store_nxt_s;
            busy_r  <= busy_nxt_s;
            for (int i = 0; i < NUM_COIN; i++) begin
                state_r[i]    <= state_nxt_s[i];
                timer_r[i]    <= timer_nxt_s[i];
                pend_r[i]     <= pend_nxt_s[i];
                coin_out_r[i] <= (state_nxt_s[i] == ST_PULSE);
            end
        end
    end

    assign bus.q           = q_r;
    assign bus.coin_out    = coin_out_r;
    assign bus.coin_busy   = busy_r;
    assign bus.store_pulse = store_r;

`ifdef COIN_LATCH_OVF_EN
    logic [NUM_COIN-1:0] ovf_r;
    logic [NUM_COIN-1:0] ovf_clr_s;

    // Overflow flag clears on a 1-write to the channel's own bit while it is idle
    always_comb begin
        ovf_clr_s = {NUM_COIN{1'b0}};
        for (int i = 0; i < NUM_COIN; i++) begin
            ovf_clr_s[i] = !bus.OUTn && (bus.BA == ADDR_W'(COIN_BASE + i)) && bus.BD && !busy_r[i];
        end
    end

    // Sticky overflow flags: a dropped increment wins over a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= {NUM_COIN{1'b0}};
        end else begin
            ovf_r <= drop_s | (ovf_r & ~ovf_clr_s);
        end
    end

    assign bus.coin_ovf = ovf_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = |drop_s;
`endif

endmodule

// File: doc/coin_latch_counter.md
Name: coin_latch_counter

Overview:
- Parametrised addressable output latch (259-style) for CPU-driven control bits: bank select, coin counters, NVRAM recall/store, LEDs.
- Adds per-channel coin-counter pulse shaping. Each 0->1 write on a coin bit queues one count. Each count becomes a fixed-width pulse followed by a fixed gap, so fast CPU toggles are never lost or merged.
- Sits between the CPU output-decode strobe and the cabinet/NVRAM outputs.

Parameters:
- ADDR_W, 3, latch address width; latch has 2**ADDR_W bits.
- RESET_VAL, 0, value of q after reset (2**ADDR_W bits).
- NUM_COIN, 2, number of coin-counter channels.
- COIN_BASE, 5, latch bit index of coin channel 0; channel i uses bit COIN_BASE+i, and COIN_BASE+NUM_COIN <= 2**ADDR_W.
- PULSE_CYC, 16, coin pulse high time in clk cycles (>=1).
- GAP_CYC, 16, minimum low time between coin pulses in clk cycles (>=1).
- CNT_W, 4, pending-count width per channel; saturates at 2**CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- OUTn  in  1  active-low latch write enable, sampled on clk.
- BA  in  ADDR_W  latch bit address.
- BD  in  1  data bit written.
- q  out  2**ADDR_W  raw latch contents.
- coin_out  out  NUM_COIN  shaped coin-counter drive, active high.
- coin_busy  out  NUM_COIN  channel has a pulse in progress or pending counts.
- store_pulse  out  1  one-cycle strobe when NVRAM store condition (q[3]=1, q[2]=0) becomes true.

Behaviour:
- Reset (async assert, sync to clk on release):
  - q=RESET_VAL.
  - coin_out=0, coin_busy=0, store_pulse=0.
  - All pending counts 0, all channel FSMs IDLE, timers 0.
  - Edge-detect history is loaded from RESET_VAL, so no count is queued by reset itself.
- Latch:
  - On a clk edge with OUTn=0: q[BA] <= BD. Other bits are held.
  - OUTn=1: q holds.
  - Latch write to q is visible 1 cycle after the sampled edge.
- Coin edge detect: channel i registers inc_i when q[COIN_BASE+i] goes 0->1 between consecutive cycles. Rewriting 1 over 1, or any 1->0 transition, queues nothing.
- Pending counter, per channel:
  - +1 on inc_i.
  - -1 when the FSM leaves IDLE or GAP to start a pulse.
  - inc and start in the same cycle: net unchanged.
  - At 2**CNT_W-1, further increments are dropped (saturate, no wrap).
- Channel FSM (one per channel):
  - IDLE: coin_out=0. If pending>0 (value before this cycle's update) -> PULSE, timer=PULSE_CYC-1, consume one count.
  - PULSE: coin_out=1. Timer counts down; at 0 -> GAP, timer=GAP_CYC-1.
  - GAP: coin_out=0. Timer counts down. At 0: if pending>0 -> PULSE directly (consume one count), else -> IDLE.
- Timing of a single count:
  - Latency from the sampled write edge to coin_out rising is 3 cycles: latch, detect, start.
  - Pulse lasts exactly PULSE_CYC cycles.
  - Back-to-back pulses are separated by exactly GAP_CYC low cycles.
- coin_busy_i = (state != IDLE) | (pending>0).
- store_pulse: high for exactly one cycle when (q[3] & ~q[2]) goes 0->1. It stays low while the condition holds.
- Reset mid-pulse: coin_out drops immediately (async). Queued counts are discarded.
- Channels are fully independent; simultaneous events on different channels do not interact.

Optional Feature:
- Macro COIN_LATCH_OVF_EN.
- When defined:
  - Extra output port coin_ovf (NUM_COIN bits), one sticky flag per channel.
  - coin_ovf_i is set when inc_i arrives while pending is saturated.
  - coin_ovf_i is cleared only by reset, or by writing 1 to latch bit COIN_BASE+i while OUTn=0 and coin_busy_i=0.
  - Flag visible the cycle after the dropped increment.
- When undefined: port absent; dropped increments leave no trace; all other behaviour identical.

Test Plan:
All cases use ADDR_W=3, NUM_COIN=2, COIN_BASE=5, PULSE_CYC=4, GAP_CYC=2, CNT_W=2.
- Latch: after reset, write BD=1 to each BA 0..7 in turn -> q steps 0x01,0x03,...,0xFF. Then write BD=0 to BA=7 -> q=0x7F. OUTn=1 with changing BA/BD -> q unchanged.
- Single coin: write bit5 0 then 1 -> coin_out[0] rises 3 cycles after the write edge, stays high 4 cycles, then low. coin_busy[0] clears when the FSM returns to IDLE. coin_out[1] stays 0.
- Burst: toggle bit6 0/1 three times in 6 cycles -> three pulses on coin_out[1], each 4 high, separated by 2 low.
- Saturation: five 0->1 edges on bit5 within 10 cycles -> at most 1 in progress + 3 pending emitted, so 4 pulses. With COIN_LATCH_OVF_EN, coin_ovf[0]=1 until cleared.
- Store: write bit3=1 with bit2=0 -> store_pulse high exactly 1 cycle. Rewrite bit3=1 -> no pulse. Set bit2=1 then 0 -> second pulse.
- Reset mid-pulse: assert reset during PULSE with 2 pending -> coin_out=0 immediately, coin_busy=0. After release, no further pulses.
